// File: rtl/mc_burst_mem.sv
// Paged burst memory slave on a multiplexed address/data bus.
// Each accepted address cycle is followed by PAYLOAD read or write data cycles.
module mc_burst_mem #(
  parameter int unsigned         BUSWIDTH = 16,
  parameter int unsigned         PAGEBITS = 4,
  parameter int unsigned         PAYLOAD  = 4,
  parameter int unsigned         MEMSIZE  = 256,
  parameter logic [PAGEBITS-1:0] MEMPAGE  = 4'h2
) (
  input  logic                clk,
  input  logic                resetN,
  input  logic                addrValid,
  input  logic                rw,
  input  logic [BUSWIDTH-1:0] busIn,
  output logic [BUSWIDTH-1:0] busOut,
  output logic                busOutEn,
  output logic                busy
);

  localparam int unsigned AW = $clog2(MEMSIZE);
  localparam int unsigned CW = $clog2(PAYLOAD) + 1;

  typedef enum logic [1:0] {StIdle, StWrite, StRead} state_e;

  state_e                state_q, state_d;
  logic [CW-1:0]         counter_q, counter_d;
  logic [AW-1:0]         base_q, base_d;
  logic [BUSWIDTH-1:0]   bus_out_q, bus_out_d;
  logic                  bus_out_en_q, bus_out_en_d;
  logic                  busy_q, busy_d;

  logic [BUSWIDTH-1:0]   mem [MEMSIZE];
  logic [AW-1:0]         loc_in;
  logic                  page_hit;
  logic [AW-1:0]         wr_idx;
  logic [AW-1:0]         rd_idx;
  logic [BUSWIDTH-1:0]   rd_data;
  logic                  mem_we;
  logic [CW-1:0]         counter_inc;
  logic                  unused_bus;

  // Location bits above AW alias onto the same words.
  assign loc_in      = busIn[AW-1:0];
  assign page_hit    = addrValid && (busIn[BUSWIDTH-1 -: PAGEBITS] == MEMPAGE);
  assign counter_inc = counter_q + CW'(1);
  assign wr_idx      = base_q + AW'(counter_q);
  assign unused_bus  = ^busIn;

  // The idle read port looks up the incoming base so the first word is ready at the address edge.
  always_comb begin
    rd_idx = base_q + AW'(counter_inc);
    if (state_q == StIdle) begin
      rd_idx = loc_in;
    end
  end

  assign rd_data = mem[rd_idx];

  always_comb begin
    state_d      = state_q;
    counter_d    = counter_q;
    base_d       = base_q;
    bus_out_d    = bus_out_q;
    bus_out_en_d = bus_out_en_q;
    busy_d       = busy_q;
    mem_we       = 1'b0;
    unique case (state_q)
      StIdle: begin
        if (page_hit) begin
          base_d    = loc_in;
          counter_d = '0;
          busy_d    = 1'b1;
          if (rw) begin
            state_d      = StRead;
            bus_out_d    = rd_data;
            bus_out_en_d = 1'b1;
          end else begin
            state_d = StWrite;
          end
        end
      end
      StWrite: begin
        mem_we    = 1'b1;
        counter_d = counter_inc;
        if (counter_q == CW'(PAYLOAD - 1)) begin
          state_d = StIdle;
          busy_d  = 1'b0;
        end
      end
      StRead: begin
        counter_d = counter_inc;
        if (counter_inc < CW'(PAYLOAD)) begin
          bus_out_d = rd_data;
        end else begin
          bus_out_d    = '0;
          bus_out_en_d = 1'b0;
          busy_d       = 1'b0;
          state_d      = StIdle;
        end
      end
      default: begin
        state_d = StIdle;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (!resetN) begin
      state_q      <= StIdle;
      counter_q    <= '0;
      base_q       <= '0;
      bus_out_q    <= '0;
      bus_out_en_q <= 1'b0;
      busy_q       <= 1'b0;
    end else begin
      state_q      <= state_d;
      counter_q    <= counter_d;
      base_q       <= base_d;
      bus_out_q    <= bus_out_d;
      bus_out_en_q <= bus_out_en_d;
      busy_q       <= busy_d;
    end
  end

  // Array is not reset; a reset edge still suppresses the write.
  always_ff @(posedge clk) begin
    if (resetN && mem_we) begin
      mem[wr_idx] <= busIn;
    end
  end

  assign busOut   = bus_out_q;
  assign busOutEn = bus_out_en_q;
  assign busy     = busy_q;

endmodule

// File: tb/tb_mc_burst_mem.sv
// Scoreboard bench for mc_burst_mem: default instance plus a 32-bit/8-word instance,
// with expected read words queued at issue time and popped by per-instance monitors.
module tb_mc_burst_mem;

  logic        clk = 1'b0;
  always #5 clk = ~clk;

  logic        rstn;
  logic        av_a, rw_a, en_a, busy_a;
  logic [15:0] bus_a, out_a;
  logic        av_b, rw_b, en_b, busy_b;
  logic [31:0] bus_b, out_b;

  mc_burst_mem dut_a (
    .clk      (clk),
    .resetN   (rstn),
    .addrValid(av_a),
    .rw       (rw_a),
    .busIn    (bus_a),
    .busOut   (out_a),
    .busOutEn (en_a),
    .busy     (busy_a)
  );

  mc_burst_mem #(
    .BUSWIDTH(32),
    .PAGEBITS(8),
    .PAYLOAD (8),
    .MEMSIZE (1024),
    .MEMPAGE (8'hA5)
  ) dut_b (
    .clk      (clk),
    .resetN   (rstn),
    .addrValid(av_b),
    .rw       (rw_b),
    .busIn    (bus_b),
    .busOut   (out_b),
    .busOutEn (en_b),
    .busy     (busy_b)
  );

  int          n_cmp = 0;
  int          n_bad = 0;
  bit          mon_on = 1'b0;
  logic [31:0] mdl   [2][1024];
  bit          known [2][1024];
  logic [32:0] q_a[$];
  logic [32:0] q_b[$];
  logic [32:0] e_a, e_b;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h want %h at %0t", name, act, exp, $time);
    end
  endtask

  function automatic int size_of(input int s);
    return (s == 0) ? 256 : 1024;
  endfunction

  function automatic int words_of(input int s);
    return (s == 0) ? 4 : 8;
  endfunction

  function automatic logic busy_of(input int s);
    return (s == 0) ? busy_a : busy_b;
  endfunction

  function automatic logic en_of(input int s);
    return (s == 0) ? en_a : en_b;
  endfunction

  task automatic drive(input int s, input logic av, input logic r, input logic [31:0] v);
    if (s == 0) begin
      av_a = av; rw_a = r; bus_a = v[15:0];
    end else begin
      av_b = av; rw_b = r; bus_b = v;
    end
  endtask

  task automatic push_exp(input int s, input logic [32:0] e);
    if (s == 0) q_a.push_back(e);
    else q_b.push_back(e);
  endtask

  // fix != 0 gives data fix*(i+1); inj is the data-cycle index of a stray addrValid; rst_at
  // is the data-cycle index whose edge sees resetN low (-1 = none).
  task automatic burst(input int s, input bit rd, input logic [31:0] addr, input logic [31:0] fix,
                       input int inj, input logic [31:0] inj_addr, input int rst_at);
    int          sz, p, loc, idx;
    bit          hit;
    logic [31:0] d;
    sz  = size_of(s);
    p   = words_of(s);
    hit = (s == 0) ? (addr[15:12] == 4'h2) : (addr[31:24] == 8'hA5);
    loc = int'(addr[9:0]) % sz;
    drive(s, 1'b1, rd, addr);
    if (hit && rd) begin
      for (int i = 0; i < p; i++) begin
        idx = (loc + i) % sz;
        push_exp(s, {known[s][idx], mdl[s][idx]});
      end
    end
    @(posedge clk); #1;
    chk("busy_after_addr", 32'(busy_of(s)), 32'(hit));
    for (int i = 0; i < p; i++) begin
      d = (fix != 0) ? fix * (i + 1) : $urandom;
      if (s == 0) d = d & 32'h0000_FFFF;
      if (i == inj) drive(s, 1'b1, 1'b0, rd ? inj_addr : d);
      else drive(s, 1'b0, 1'b0, d);
      if (i == rst_at) rstn = 1'b0;
      @(posedge clk); #1;
      if (i == rst_at) begin
        chk("busy_after_reset", 32'(busy_of(s)), 32'd0);
        chk("en_after_reset", 32'(en_of(s)), 32'd0);
        rstn = 1'b1;
        drive(s, 1'b0, 1'b0, 32'd0);
        return;
      end
      if (hit && !rd) begin
        idx = (loc + i) % sz;
        mdl[s][idx]   = d;
        known[s][idx] = 1'b1;
      end
      chk("busy_in_burst", 32'(busy_of(s)), 32'(hit && (i < p - 1)));
    end
    drive(s, 1'b0, 1'b0, 32'd0);
  endtask

  always @(negedge clk) begin
    if (mon_on) begin
      if (en_a) begin
        if (q_a.size() == 0) begin
          chk("a_unexpected_read", 32'(en_a), 32'd0);
        end else begin
          e_a = q_a.pop_front();
          if (e_a[32]) chk("a_read_data", {16'd0, out_a}, e_a[31:0]);
        end
      end else begin
        chk("a_idle_bus", {16'd0, out_a}, 32'd0);
      end
    end
  end

  always @(negedge clk) begin
    if (mon_on) begin
      if (en_b) begin
        if (q_b.size() == 0) begin
          chk("b_unexpected_read", 32'(en_b), 32'd0);
        end else begin
          e_b = q_b.pop_front();
          if (e_b[32]) chk("b_read_data", out_b, e_b[31:0]);
        end
      end else begin
        chk("b_idle_bus", out_b, 32'd0);
      end
    end
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: got timeout want finish");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [31:0] addr;
    bit          rd;
    int          inj;
    rstn = 1'b0;
    drive(0, 1'b0, 1'b0, 32'd0);
    drive(1, 1'b0, 1'b0, 32'd0);
    repeat (2) @(posedge clk);
    #1;
    chk("reset_busy_a", 32'(busy_a), 32'd0);
    chk("reset_en_a", 32'(en_a), 32'd0);
    chk("reset_out_a", {16'd0, out_a}, 32'd0);
    chk("reset_busy_b", 32'(busy_b), 32'd0);
    chk("reset_en_b", 32'(en_b), 32'd0);
    chk("reset_out_b", out_b, 32'd0);
    rstn   = 1'b1;
    mon_on = 1'b1;
    @(posedge clk); #1;

    // Basic write/read-back, page mismatch, wrap and aliasing.
    burst(0, 1'b0, 32'h2010, 32'h1111, -1, 32'd0, -1);
    burst(0, 1'b1, 32'h2010, 32'd0, -1, 32'd0, -1);
    burst(0, 1'b0, 32'h3010, 32'hAAAA, -1, 32'd0, -1);
    burst(0, 1'b1, 32'h2010, 32'd0, -1, 32'd0, -1);
    burst(0, 1'b0, 32'h2000, 32'd0, -1, 32'd0, -1);
    burst(0, 1'b0, 32'h20FE, 32'd1, -1, 32'd0, -1);
    burst(0, 1'b1, 32'h2000, 32'd0, -1, 32'd0, -1);
    burst(0, 1'b1, 32'h20FE, 32'd0, -1, 32'd0, -1);
    burst(0, 1'b1, 32'h21FE, 32'd0, -1, 32'd0, -1);

    // Stray addrValid during a read must not disturb it or write mem[20h].
    burst(0, 1'b0, 32'h2020, 32'd0, -1, 32'd0, -1);
    burst(0, 1'b1, 32'h2010, 32'd0, 1, 32'h2020, -1);
    burst(0, 1'b1, 32'h2020, 32'd0, -1, 32'd0, -1);

    // Reset at the third data edge keeps only two new words.
    burst(0, 1'b0, 32'h2040, 32'd0, -1, 32'd0, -1);
    burst(0, 1'b0, 32'h2040, 32'h0101, -1, 32'd0, 2);
    burst(0, 1'b1, 32'h2040, 32'd0, -1, 32'd0, -1);

    // Wide instance, wrapping 3FF -> 000.
    burst(1, 1'b0, 32'hA500_03FC, 32'd0, -1, 32'd0, -1);
    burst(1, 1'b1, 32'hA500_03FC, 32'd0, -1, 32'd0, -1);

    for (int s = 0; s < 2; s++) begin
      for (int n = 0; n < 40; n++) begin
        addr = $urandom;
        if ($urandom_range(0, 3) != 0) begin
          if (s == 0) addr[15:12] = 4'h2;
          else addr[31:24] = 8'hA5;
        end
        if (s == 0) addr[31:16] = 16'd0;
        rd  = ($urandom_range(0, 1) == 1);
        inj = -1;
        if ((s == 0 ? addr[15:12] == 4'h2 : addr[31:24] == 8'hA5) && $urandom_range(0, 2) == 0)
          inj = $urandom_range(0, words_of(s) - 1);
        burst(s, rd, addr, 32'd0, inj, $urandom, -1);
        if ($urandom_range(0, 3) == 0) begin
          @(posedge clk); #1;
        end
      end
    end

    repeat (4) @(posedge clk);
    #1;
    chk("a_queue_drained", q_a.size(), 32'd0);
    chk("b_queue_drained", q_b.size(), 32'd0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule

// File: doc/mc_burst_mem.md
Name: mc_burst_mem

Overview:
- Parametrised successor to the fixed 16-bit, 4-word memory controller: one paged memory slave on the multiplexed address/data processor bus.
- Decodes a page number from the address cycle and accepts a burst of PAYLOAD consecutive words, read or write.
- The on-chip array is MEMSIZE words.
- Bus width, page-field width, payload length, memory depth and page number are all parameters. Adds a busy flag, wrap-around addressing and explicit mid-burst rules.

Parameters:
- BUSWIDTH, 16, width of the address/data bus and of each memory word.
- PAGEBITS, 4, width of the page field. The page field is the top PAGEBITS bits of the address word; the remaining bits are the location.
- PAYLOAD, 4, words per burst (>=1).
- MEMSIZE, 256, words in the array (power of 2, <= 2^(BUSWIDTH-PAGEBITS)).
- MEMPAGE, 4'h2, page this instance responds to (PAGEBITS wide).

Ports:
- clk  in  1  rising-edge clock.
- resetN  in  1  synchronous, active-low reset.
- addrValid  in  1  high for exactly one cycle: the address cycle.
- rw  in  1  sampled with addrValid; 1 = read, 0 = write.
- busIn  in  BUSWIDTH  address in the address cycle; write data in data cycles.
- busOut  out  BUSWIDTH  read data (registered).
- busOutEn  out  1  high while busOut carries valid read data (external tristate enable).
- busy  out  1  high while a burst is in progress.

Behaviour:
- Reset (resetN low at a clk edge):
  - state = IDLE; busOut = 0, busOutEn = 0, busy = 0; word counter = 0.
  - Array contents are not reset.
  - Reset mid-burst aborts the burst on that edge. No further writes occur and busOutEn is 0 the next cycle.
- State machine: IDLE, WRITE, READ.
- IDLE:
  - At an edge with addrValid = 1 and busIn page field == MEMPAGE:
    - latch base = busIn location bits mod MEMSIZE; counter = 0; busy = 1.
    - rw = 0: go to WRITE.
    - rw = 1: go to READ and register busOut <= mem[base], busOutEn <= 1.
  - A page mismatch, or addrValid = 0, stays in IDLE with no output change.
- WRITE:
  - Data cycles are the PAYLOAD cycles immediately after the address cycle.
  - Each edge writes mem[(base+counter) mod MEMSIZE] <= busIn, then counter++.
  - At the edge writing word PAYLOAD-1: go to IDLE, busy <= 0.
- READ:
  - busOut is valid for cycles 1..PAYLOAD after the address cycle. Word i is mem[(base+i) mod MEMSIZE].
  - Each edge: counter++. If counter+1 < PAYLOAD, busOut <= mem[(base+counter+1) mod MEMSIZE]. Otherwise busOutEn <= 0, busOut <= 0, busy <= 0, go to IDLE.
  - Read latency: the first word appears on the cycle after addrValid.
- Address arithmetic: index = (base + counter) truncated to log2(MEMSIZE) bits, so bursts wrap from MEMSIZE-1 to 0.
- Location bits above log2(MEMSIZE) are ignored (aliasing).
- addrValid while busy is ignored regardless of page; the current burst completes unaffected.
- Back-to-back: addrValid in the first cycle after busy drops is accepted. Total occupancy is PAYLOAD+1 cycles per burst.
- Read-after-write to the same location in the next burst returns the newly written data.
- Counter width: clog2(PAYLOAD)+1 bits.

Test Plan (defaults unless stated):
1. Write burst at 16'h2010 with data 16'h1111, 16'h2222, 16'h3333, 16'h4444, then read at 16'h2010 -> busOutEn high cycles 1-4 after addrValid, busOut = 1111, 2222, 3333, 4444, then busOutEn = 0, busOut = 0; busy high exactly 4 cycles per burst.
2. Page mismatch: write at 16'h3010 with data AAAA.., then read at 16'h2010 -> busy never asserts on the write; read returns the test-1 data unchanged.
3. Wrap: write at 16'h20FE with data 1, 2, 3, 4 -> reading at 16'h2000 returns 3, 4; reading at 16'h20FE returns 1, 2, 3, 4. Aliasing: reading at 16'h21FE also returns 1, 2, 3, 4.
4. Mid-burst addrValid: during a read at 16'h2010, pulse addrValid with 16'h2020, rw = 0 in data cycle 2 -> read continues with the test-1 values; mem[20h] unchanged.
5. Reset mid-burst: start a write at 16'h2040, deassert resetN after word 2 -> only mem[40h] and mem[41h] updated; busy = 0, busOutEn = 0 after the reset edge; a read at 16'h2040 afterwards works normally.
6. Parameter sweep: BUSWIDTH = 32, PAGEBITS = 8, PAYLOAD = 8, MEMSIZE = 1024, MEMPAGE = 8'hA5. Write and read back 8 words at 32'hA50003FC -> data matches, including the wrap at 3FF->000.
